// File: rtl/chooser_update_if.sv
// rtl/chooser_update_if.sv - branch-resolution event channel into the chooser updater
interface chooser_update_if #(
  parameter int INDEX_LEN = 8
);
  logic                 resolve_valid;
  logic                 resolve_ready;
  logic [INDEX_LEN-1:0] resolve_index;
  logic                 resolve_mispredict;

  modport master (
    output resolve_valid,
    output resolve_index,
    output resolve_mispredict,
    input  resolve_ready
  );

  modport slave (
    input  resolve_valid,
    input  resolve_index,
    input  resolve_mispredict,
    output resolve_ready
  );
endinterface

// File: rtl/chooser_update.sv
// rtl/chooser_update.sv - tournament chooser table: resolution FIFO, two-stage counter RMW, predict-side read
module chooser_update #(
  parameter int INDEX_LEN  = 8,
  parameter int CTR_WIDTH  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 is_stalling,
  chooser_update_if.slave      resolve,
  output logic [INDEX_LEN-1:0] query_index,
  input  logic                 had_guessed_global,
  input  logic                 were_equal,
  input  logic [INDEX_LEN-1:0] lookup_index,
  output logic                 use_global,
  output logic                 update_valid,
  output logic [INDEX_LEN-1:0] update_index
);
  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam int ENTRIES = 1 << INDEX_LEN;
  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
  localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'(1);

  // FIFO entry: {mispredict, index}
  logic [INDEX_LEN:0]   fifo_mem [FIFO_DEPTH];
  logic [PW:0]          wr_ptr, rd_ptr;
  logic                 empty, full, push, pop;
  logic [INDEX_LEN:0]   head;

  logic [CTR_WIDTH-1:0] ctr_table [ENTRIES];

  logic                 s1_valid, s1_hgg, s1_eq, s1_misp, s1_write;
  logic [INDEX_LEN-1:0] s1_index;
  logic [CTR_WIDTH-1:0] s1_ctr, s1_next, s0_ctr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign push  = resolve.resolve_valid && !full;
  assign pop   = !empty && !is_stalling;
  assign head  = fifo_mem[rd_ptr[PW-1:0]];

  assign resolve.resolve_ready = !full;
  assign query_index = empty ? '0 : head[INDEX_LEN-1:0];
  assign use_global  = ctr_table[lookup_index][CTR_WIDTH-1];

  assign s1_write = s1_valid && !is_stalling;

  always_comb begin
    s1_next = s1_ctr;
    if (!s1_eq) begin
      if (s1_hgg ^ s1_misp) begin
        if (s1_ctr != CTR_MAX) s1_next = s1_ctr + CTR_WIDTH'(1);
      end else begin
        if (s1_ctr != '0) s1_next = s1_ctr - CTR_WIDTH'(1);
      end
    end
  end

  // Forward the value stage 1 is writing this edge so back-to-back hits on one entry accumulate.
  assign s0_ctr = (s1_write && (s1_index == query_index)) ? s1_next : ctr_table[query_index];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr[PW-1:0]] <= {resolve.resolve_mispredict, resolve.resolve_index};
        wr_ptr <= wr_ptr + (PW+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid     <= 1'b0;
      s1_index     <= '0;
      s1_hgg       <= 1'b0;
      s1_eq        <= 1'b0;
      s1_misp      <= 1'b0;
      s1_ctr       <= '0;
      update_valid <= 1'b0;
      update_index <= '0;
    end else begin
      if (!is_stalling) begin
        s1_valid <= pop;
        if (pop) begin
          s1_index <= query_index;
          s1_hgg   <= had_guessed_global;
          s1_eq    <= were_equal;
          s1_misp  <= head[INDEX_LEN];
          s1_ctr   <= s0_ctr;
        end
      end
      update_valid <= s1_write;
      if (s1_write) update_index <= s1_index;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) ctr_table[i] <= CTR_INIT;
    end else if (s1_write) begin
      ctr_table[s1_index] <= s1_next;
    end
  end
endmodule

// File: tb/tb_chooser_update.sv
// tb/tb_chooser_update.sv - directed self-checking bench for chooser_update
module tb_chooser_update;
  localparam int IL = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          is_stalling;
  logic [IL-1:0] query_index, lookup_index, update_index;
  logic          had_guessed_global, were_equal, use_global, update_valid;
  logic [IL-1:0] lk;

  logic          hist_hgg [256];
  logic          hist_eq  [256];

  chooser_update_if #(.INDEX_LEN(IL)) rif ();

  always #5 clk = ~clk;

  assign had_guessed_global = hist_hgg[query_index];
  assign were_equal         = hist_eq[query_index];
  assign lookup_index       = lk;

  chooser_update #(.INDEX_LEN(IL), .CTR_WIDTH(2), .FIFO_DEPTH(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .is_stalling        (is_stalling),
    .resolve            (rif.slave),
    .query_index        (query_index),
    .had_guessed_global (had_guessed_global),
    .were_equal         (were_equal),
    .lookup_index       (lookup_index),
    .use_global         (use_global),
    .update_valid       (update_valid),
    .update_index       (update_index)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [IL-1:0] log_idx [$];
  logic          log_ug  [$];
  int            log_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && update_valid) begin
      log_idx.push_back(update_index);
      log_ug.push_back(use_global);
      log_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [IL-1:0] idx, input logic misp);
    rif.resolve_valid      = 1'b1;
    rif.resolve_index      = idx;
    rif.resolve_mispredict = misp;
    tick();
    rif.resolve_valid      = 1'b0;
  endtask

  task automatic clear_log;
    log_idx.delete();
    log_ug.delete();
    log_cyc.delete();
  endtask

  typedef struct {
    logic [IL-1:0] idx;
    logic          misp;
    logic          hgg;
    logic          eq;
    logic          exp_ug;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int acc;
    int accepted;
    for (int i = 0; i < 256; i++) begin
      hist_hgg[i] = 1'b0;
      hist_eq[i]  = 1'b0;
    end
    reset = 1'b1;
    is_stalling = 1'b0;
    rif.resolve_valid = 1'b0;
    rif.resolve_index = '0;
    rif.resolve_mispredict = 1'b0;
    lk = '0;

    // Reset state
    tick();
    tick();
    chk("rst_ready", rif.resolve_ready, 1);
    chk("rst_update_valid", update_valid, 0);
    chk("rst_update_index", update_index, 0);
    chk("rst_query_index", query_index, 0);
    lk = 8'd0;   #1; chk("rst_ug0", use_global, 0);
    lk = 8'd5;   #1; chk("rst_ug5", use_global, 0);
    lk = 8'd255; #1; chk("rst_ug255", use_global, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_ready", rif.resolve_ready, 1);

    // Single events: idx, mispredict, hist guessed-global, hist equal, expected MSB after write
    vecs[0] = '{idx: 8'd5,  misp: 1'b0, hgg: 1'b1, eq: 1'b0, exp_ug: 1'b1}; // 1->2
    vecs[1] = '{idx: 8'd7,  misp: 1'b0, hgg: 1'b1, eq: 1'b1, exp_ug: 1'b0}; // equal: stays 1
    vecs[2] = '{idx: 8'd9,  misp: 1'b1, hgg: 1'b0, eq: 1'b0, exp_ug: 1'b1}; // 1->2
    vecs[3] = '{idx: 8'd5,  misp: 1'b1, hgg: 1'b1, eq: 1'b0, exp_ug: 1'b0}; // 2->1
    vecs[4] = '{idx: 8'd11, misp: 1'b0, hgg: 1'b0, eq: 1'b0, exp_ug: 1'b0}; // 1->0
    vecs[5] = '{idx: 8'd11, misp: 1'b1, hgg: 1'b0, eq: 1'b0, exp_ug: 1'b0}; // 0->1
    vecs[6] = '{idx: 8'd11, misp: 1'b1, hgg: 1'b0, eq: 1'b0, exp_ug: 1'b1}; // 1->2
    for (int v = 0; v < 7; v++) begin
      hist_hgg[vecs[v].idx] = vecs[v].hgg;
      hist_eq[vecs[v].idx]  = vecs[v].eq;
      lk = vecs[v].idx;
      clear_log();
      send(vecs[v].idx, vecs[v].misp);
      acc = cyc;
      tick();
      chk($sformatf("v%0d_no_early_update", v), update_valid, 0);
      tick();
      tick();
      chk($sformatf("v%0d_update_count", v), log_idx.size(), 1);
      if (log_idx.size() > 0) begin
        chk($sformatf("v%0d_update_index", v), log_idx[0], vecs[v].idx);
        chk($sformatf("v%0d_update_cycle", v), log_cyc[0], acc + 2);
        chk($sformatf("v%0d_use_global", v), log_ug[0], vecs[v].exp_ug);
      end
    end

    // Back-to-back on idx 3: three toward global, four toward local -> 2,3,3,2,1,0,0
    begin
      logic exp_ug [7];
      exp_ug = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      hist_hgg[3] = 1'b1;
      hist_eq[3]  = 1'b0;
      lk = 8'd3;
      clear_log();
      send(8'd3, 1'b0);
      acc = cyc;
      send(8'd3, 1'b0);
      send(8'd3, 1'b0);
      send(8'd3, 1'b1);
      send(8'd3, 1'b1);
      send(8'd3, 1'b1);
      send(8'd3, 1'b1);
      repeat (4) tick();
      chk("b2b_update_count", log_idx.size(), 7);
      for (int k = 0; k < 7; k++) begin
        if (k < log_idx.size()) begin
          chk($sformatf("b2b%0d_use_global", k), log_ug[k], exp_ug[k]);
          chk($sformatf("b2b%0d_update_cycle", k), log_cyc[k], acc + 2 + k);
        end
      end
    end

    // Stall: offer six events, only four fit
    for (int i = 40; i < 46; i++) begin
      hist_hgg[i] = 1'b1;
      hist_eq[i]  = 1'b0;
    end
    clear_log();
    lk = 8'd40;
    is_stalling = 1'b1;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      rif.resolve_valid = 1'b1;
      rif.resolve_index = IL'(40 + i);
      rif.resolve_mispredict = 1'b0;
      if (rif.resolve_ready) accepted++;
      tick();
    end
    rif.resolve_valid = 1'b0;
    repeat (2) tick();
    chk("stall_accepted", accepted, 4);
    chk("stall_ready_low", rif.resolve_ready, 0);
    chk("stall_no_update", log_idx.size(), 0);
    is_stalling = 1'b0;
    #1;
    chk("stall_release_ready_still_low", rif.resolve_ready, 0);
    acc = cyc;
    tick();
    chk("stall_ready_after_pop", rif.resolve_ready, 1);
    repeat (5) tick();
    chk("stall_update_count", log_idx.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < log_idx.size()) begin
        chk($sformatf("stall%0d_index", k), log_idx[k], 40 + k);
        chk($sformatf("stall%0d_cycle", k), log_cyc[k], acc + 2 + k);
      end
    end
    lk = 8'd43; #1;
    chk("stall_last_use_global", use_global, 1);

    // Reset mid-operation: stage 1 holds idx 20, FIFO full
    hist_hgg[20] = 1'b1;
    hist_eq[20]  = 1'b0;
    clear_log();
    is_stalling = 1'b1;
    send(8'd20, 1'b0);
    send(8'd21, 1'b0);
    send(8'd22, 1'b0);
    send(8'd23, 1'b0);
    is_stalling = 1'b0;
    tick();
    is_stalling = 1'b1;
    send(8'd24, 1'b0);
    chk("mid_ready_full", rif.resolve_ready, 0);
    chk("mid_no_update", log_idx.size(), 0);
    reset = 1'b1;
    lk = 8'd20;
    #1;
    chk("mid_rst_ready", rif.resolve_ready, 1);
    chk("mid_rst_update_valid", update_valid, 0);
    chk("mid_rst_query_index", query_index, 0);
    chk("mid_rst_use_global20", use_global, 0);
    repeat (2) tick();
    reset = 1'b0;
    is_stalling = 1'b0;
    repeat (5) tick();
    chk("mid_rst_no_update_after", log_idx.size(), 0);
    chk("mid_rst_use_global20_after", use_global, 0);
    chk("mid_rst_ready_after", rif.resolve_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
